control_sequencer: RTL and testbench

//   Hardwired control unit for the Datapath. Steps through the fetch (T0-T2)
//   and execute (T3-T5) cycles, decoding the IR contents driven back from the

---
 rtl/control_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for a single-bus datapath.
// Walks the fetch phase (T0-T2) and the execute phase (T3-T5), decoding the
// IR driven back by the datapath. The only state held here is the step
// register. Every strobe is a combinational decode of that register, plus
// the IR fields during T3-T5.
module control_sequencer #(
   parameter logic [4:0] OPC_ADD  = 5'b00011,
   parameter logic [4:0] OPC_SUB  = 5'b00100,
   parameter logic [4:0] OPC_AND  = 5'b00101,
   parameter logic [4:0] OPC_OR   = 5'b00110,
   parameter logic [4:0] OPC_NOP  = 5'b11010,
   parameter logic [4:0] OPC_HALT = 5'b11011
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic [31:0] IR,
   input  logic        Stop,
   output logic        PCout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        MARin,
   output logic        Zin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        IncPC,
   output logic        Read,
   output logic [15:0] Rin,
   output logic [15:0] Rout,
   output logic [4:0]  operation,
   output logic        Run,
   output logic        Illegal,
   output logic [3:0]  Present_state
);

   // Step encoding. These values appear on Present_state for debug.
   typedef enum logic [3:0] {
      S_RST  = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_HALT = 4'd7
   } state_e;

   state_e state_q;
   state_e state_d;

   // Instruction fields. They are meaningful only from T3 on, once the
   // fetch has loaded IR.
   logic [4:0] opcode;
   logic [3:0] ra;
   logic [3:0] rb;
   logic [3:0] rc;
   logic       is_alu;
   logic       is_nop;
   logic       is_halt;
   logic       is_illegal;
   logic       unused_ir_bits;

   assign opcode = IR[31:27];
   assign ra     = IR[26:23];
   assign rb     = IR[22:19];
   assign rc     = IR[18:15];

   // IR[14:0] carry no information for the supported instruction set.
   assign unused_ir_bits = ^IR[14:0];

   // Opcode classification. Any unsupported opcode is flagged and then
   // retired as though it were a NOP.
   always_comb begin
      is_alu     = 1'b0;
      is_nop     = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      if ((opcode == OPC_ADD) || (opcode == OPC_SUB) ||
          (opcode == OPC_AND) || (opcode == OPC_OR)) begin
         is_alu = 1'b1;
      end else if (opcode == OPC_NOP) begin
         is_nop = 1'b1;
      end else if (opcode == OPC_HALT) begin
         is_halt = 1'b1;
      end else begin
         is_illegal = 1'b1;
      end
   end

   // Step register. An asynchronous reset abandons any instruction in flight.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_RST;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-step logic. Stop is looked at only when an instruction completes,
   // which is on leaving T5, or on leaving T3 for a NOP or illegal opcode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_RST:  state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   state_d = S_T2;
         S_T2:   state_d = S_T3;
         S_T3: begin
            if (is_alu) begin
               state_d = S_T4;
            end else if (is_halt) begin
               state_d = S_HALT;
            end else begin
               state_d = Stop ? S_HALT : S_T0;
            end
         end
         S_T4:   state_d = S_T5;
         S_T5:   state_d = Stop ? S_HALT : S_T0;
         S_HALT: state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   // Strobe decode. Every output is 0 unless the current step drives it.
   always_comb begin
      PCout     = 1'b0;
      Zlowout   = 1'b0;
      MDRout    = 1'b0;
      MARin     = 1'b0;
      Zin       = 1'b0;
      PCin      = 1'b0;
      MDRin     = 1'b0;
      IRin      = 1'b0;
      Yin       = 1'b0;
      IncPC     = 1'b0;
      Read      = 1'b0;
      Rin       = 16'h0000;
      Rout      = 16'h0000;
      operation = 5'b00000;
      Run       = 1'b0;
      Illegal   = 1'b0;
      unique case (state_q)
         S_T0: begin
            Run   = 1'b1;
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         S_T1: begin
            Run     = 1'b1;
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         S_T2: begin
            Run    = 1'b1;
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            Run = 1'b1;
            if (is_alu) begin
               Rout = 16'h0001 << rb;
               Yin  = 1'b1;
            end
            Illegal = is_illegal;
         end
         S_T4: begin
            Run       = 1'b1;
            Rout      = 16'h0001 << rc;
            Zin       = 1'b1;
            operation = opcode;
         end
         S_T5: begin
            Run     = 1'b1;
            Zlowout = 1'b1;
            Rin     = 16'h0001 << ra;
         end
         default: begin
            // RST and HALT drive no strobes. Run is already 0 from the defaults.
         end
      endcase
   end

   assign Present_state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer. A reference model expands each instruction
// into the list of expected per-cycle output vectors, taken from the
// instruction's class (ALU / NOP / HALT / unsupported). Directed cases run
// first, then randomized instruction streams with Stop pulses, halts and
// resets placed at random points.
module tb_control_sequencer;

   localparam logic [4:0] OPC_ADD  = 5'b00011;
   localparam logic [4:0] OPC_SUB  = 5'b00100;
   localparam logic [4:0] OPC_AND  = 5'b00101;
   localparam logic [4:0] OPC_OR   = 5'b00110;
   localparam logic [4:0] OPC_NOP  = 5'b11010;
   localparam logic [4:0] OPC_HALT = 5'b11011;

   typedef struct packed {
      logic        pc_out;
      logic        zlow_out;
      logic        mdr_out;
      logic        mar_in;
      logic        z_in;
      logic        pc_in;
      logic        mdr_in;
      logic        ir_in;
      logic        y_in;
      logic        inc_pc;
      logic        read;
      logic [15:0] rin;
      logic [15:0] rout;
      logic [4:0]  op;
      logic        run;
      logic        illegal;
      logic [3:0]  st;
   } ctl_t;

   localparam int W = $bits(ctl_t);

   logic        Clock;
   logic        Reset_n;
   logic [31:0] IR;
   logic        Stop;
   logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
   logic        IncPC, Read, Run, Illegal;
   logic [15:0] Rin, Rout;
   logic [4:0]  operation;
   logic [3:0]  Present_state;

   logic [W-1:0] exp_q[$];
   int           n_vec;
   int           n_err;

   control_sequencer dut (
      .Clock         (Clock),
      .Reset_n       (Reset_n),
      .IR            (IR),
      .Stop          (Stop),
      .PCout         (PCout),
      .Zlowout       (Zlowout),
      .MDRout        (MDRout),
      .MARin         (MARin),
      .Zin           (Zin),
      .PCin          (PCin),
      .MDRin         (MDRin),
      .IRin          (IRin),
      .Yin           (Yin),
      .IncPC         (IncPC),
      .Read          (Read),
      .Rin           (Rin),
      .Rout          (Rout),
      .operation     (operation),
      .Run           (Run),
      .Illegal       (Illegal),
      .Present_state (Present_state)
   );

   // Clock and reset: posedges at 5, 15, 25, ... Inputs are driven and
   // outputs sampled just after each negedge.
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic ctl_t obs_vec();
      ctl_t v;
      v = '{pc_out: PCout, zlow_out: Zlowout, mdr_out: MDRout, mar_in: MARin,
            z_in: Zin, pc_in: PCin, mdr_in: MDRin, ir_in: IRin, y_in: Yin,
            inc_pc: IncPC, read: Read, rin: Rin, rout: Rout, op: operation,
            run: Run, illegal: Illegal, st: Present_state};
      return v;
   endfunction

   function automatic ctl_t idle_vec(input logic [3:0] st);
      ctl_t v;
      v    = '0;
      v.st = st;
      return v;
   endfunction

   function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
      logic [31:0] ir;
      ir = {opc, ra, rb, rc, 15'h0000};
      return ir;
   endfunction

   function automatic bit is_alu_opc(input logic [4:0] opc);
      return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_AND) || (opc == OPC_OR);
   endfunction

   // Scoreboard compare: every comparison in the bench goes through here.
   task automatic check_vec(input string tag, input ctl_t obs, input ctl_t exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%h exp=%h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: queue the expected output vector for each cycle of
   // one instruction, from the fetch through to completion.
   task automatic build_instr(input logic [31:0] ir);
      ctl_t       v;
      logic [4:0] opc;
      opc = ir[31:27];
      v = '0; v.pc_out = 1; v.mar_in = 1; v.inc_pc = 1; v.z_in = 1; v.run = 1; v.st = 4'd1;
      exp_q.push_back(v);
      v = '0; v.zlow_out = 1; v.pc_in = 1; v.read = 1; v.mdr_in = 1; v.run = 1; v.st = 4'd2;
      exp_q.push_back(v);
      v = '0; v.mdr_out = 1; v.ir_in = 1; v.run = 1; v.st = 4'd3;
      exp_q.push_back(v);
      v = '0; v.run = 1; v.st = 4'd4;
      if (is_alu_opc(opc)) begin
         v.rout = 16'h0001 << ir[22:19];
         v.y_in = 1;
         exp_q.push_back(v);
         v = '0; v.rout = 16'h0001 << ir[18:15]; v.z_in = 1; v.op = opc; v.run = 1; v.st = 4'd5;
         exp_q.push_back(v);
         v = '0; v.zlow_out = 1; v.rin = 16'h0001 << ir[26:23]; v.run = 1; v.st = 4'd6;
         exp_q.push_back(v);
      end else begin
         v.illegal = (opc != OPC_NOP) && (opc != OPC_HALT);
         exp_q.push_back(v);
      end
   endtask

   // Driver: run one instruction. Stop is driven to stop_end in the final
   // cycle and pulsed elsewhere (always when stop_mid is set). If abort_at
   // is not -1, the run drops Reset_n part-way through that step.
   task automatic run_instr(input logic [31:0] ir, input bit stop_end, input bit stop_mid,
                            input int abort_at, output bit halted);
      int n;
      exp_q.delete();
      build_instr(ir);
      n      = exp_q.size();
      halted = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge Clock);
         IR   = (i < 3) ? $urandom : ir;
         Stop = (i == n - 1) ? stop_end : (stop_mid ? 1'b1 : 1'($urandom_range(0, 1)));
         #1;
         check_vec($sformatf("ir%08h_step%0d", ir, i), obs_vec(), exp_q.pop_front());
         if (i == abort_at) begin
            #2;
            Reset_n = 1'b0;
            #1;
            check_vec("async_reset", obs_vec(), idle_vec(4'd0));
            @(negedge Clock);
            #1;
            check_vec("reset_hold", obs_vec(), idle_vec(4'd0));
            Reset_n = 1'b1;
            #1;
            check_vec("reset_release", obs_vec(), idle_vec(4'd0));
            return;
         end
      end
      halted = stop_end || (ir[31:27] == OPC_HALT);
   endtask

   // Sit in HALT for n cycles, with Stop and IR toggling at random.
   task automatic run_halt(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clock);
         Stop = 1'($urandom_range(0, 1));
         IR   = $urandom;
         #1;
         check_vec($sformatf("halt%0d", i), obs_vec(), idle_vec(4'd7));
      end
   endtask

   // Apply reset for one full cycle, then release it. The DUT sits in RST
   // for the current cycle and moves to T0 on the next posedge.
   task automatic do_reset();
      @(negedge Clock);
      Reset_n = 1'b0;
      #1;
      check_vec("rst_assert", obs_vec(), idle_vec(4'd0));
      @(negedge Clock);
      #1;
      check_vec("rst_low", obs_vec(), idle_vec(4'd0));
      Reset_n = 1'b1;
      #1;
      check_vec("rst_rel", obs_vec(), idle_vec(4'd0));
   endtask

   logic [4:0] alu_ops [4];

   initial begin
      bit         h;
      int         kind;
      logic [4:0] opc;
      alu_ops[0] = OPC_ADD;
      alu_ops[1] = OPC_SUB;
      alu_ops[2] = OPC_AND;
      alu_ops[3] = OPC_OR;
      n_vec   = 0;
      n_err   = 0;
      Reset_n = 1'b0;
      Stop    = 1'b0;
      IR      = 32'h0;
      #1;
      check_vec("reset_state", obs_vec(), idle_vec(4'd0));
      @(negedge Clock);
      Reset_n = 1'b1;
      #1;
      check_vec("reset_exit", obs_vec(), idle_vec(4'd0));

      // Directed cases.
      run_instr(32'h2A1B8000, 1'b0, 1'b0, -1, h);               // AND R4,R3,R7
      run_instr(32'hD0000000, 1'b0, 1'b0, -1, h);               // NOP
      run_instr(32'hF8000000, 1'b0, 1'b0, -1, h);               // opcode 11111
      run_instr(mk_ir(OPC_ADD, 4'd1, 4'd2, 4'd3), 1'b1, 1'b0, -1, h); // Stop in T5
      run_halt(10);
      do_reset();
      run_instr(mk_ir(OPC_SUB, 4'd15, 4'd15, 4'd15), 1'b0, 1'b1, -1, h); // stray Stop ignored
      run_instr(32'hD8000000, 1'b0, 1'b0, -1, h);               // HALT
      run_halt(10);
      do_reset();
      run_instr(mk_ir(OPC_OR, 4'd0, 4'd9, 4'd12), 1'b0, 1'b0, 4, h); // reset mid-T4
      run_instr(32'hD0000000, 1'b1, 1'b0, -1, h);               // NOP + Stop
      run_halt(3);
      do_reset();

      // Randomized instruction stream.
      for (int k = 0; k < 80; k++) begin
         kind = $urandom_range(0, 11);
         if (kind <= 5)       opc = alu_ops[$urandom_range(0, 3)];
         else if (kind <= 7)  opc = OPC_NOP;
         else if (kind <= 10) opc = 5'($urandom_range(0, 31));
         else                 opc = OPC_HALT;
         run_instr({opc, 27'($urandom)}, ($urandom_range(0, 5) == 0), 1'b0,
                   ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 3)) : -1, h);
         if (h) begin
            run_halt($urandom_range(1, 10));
            do_reset();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
